// File: rtl/instr_mem_responder.sv
// Instruction memory for the fetch port: one-cycle registered reads, plus a byte-stream
// loader that packs little-endian bytes into words and holds the core in reset until loaded.
//
//   state   | meaning
//   IDLE    | out of reset, no byte taken yet
//   LOAD    | packing bytes into words
//   DONE    | image complete, core released, loader closed until reset_n
module instr_mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          ADDR_W      = $clog2(DEPTH_WORDS),
    parameter logic [31:0] END_INSTR   = 32'h0000_1111
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       address,
    output logic [31:0]       data,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic              load_overflow,
    output logic [ADDR_W:0]   word_count,
    output logic              core_reset_n
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_t;

    localparam logic [ADDR_W:0] FULL_PTR = (ADDR_W+1)'(DEPTH_WORDS);
    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);

    logic [31:0]     r_mem [DEPTH_WORDS];
    state_t          r_state;
    logic [1:0]      r_byte_cnt;
    logic [23:0]     r_word;
    logic [ADDR_W:0] r_wr_ptr;
    logic [ADDR_W:0] r_word_count;
    logic            r_ready;
    logic            r_done;
    logic            r_overflow;
    logic [31:0]     r_data;

    logic              w_accept;
    logic              w_full;
    logic              w_commit;
    logic              w_we;
    logic [31:0]       w_word;
    logic [ADDR_W-1:0] w_rd_idx;
    logic              w_out_of_range;
    logic              w_unused_addr;

    assign w_accept       = load_valid && r_ready;
    assign w_full         = (r_wr_ptr == FULL_PTR);
    assign w_commit       = (r_byte_cnt == 2'd3) || load_last;
    assign w_we           = reset_n && w_accept && !w_full && w_commit;
    assign w_rd_idx       = address[ADDR_W+1:2];
    assign w_out_of_range = |address[31:ADDR_W+2];
    assign w_unused_addr  = ^address[1:0];

    // Lanes above the incoming byte stay zero so a short final word is zero-padded.
    always_comb begin
        w_word = 32'h0;
        case (r_byte_cnt)
            2'd0:    w_word = {24'h0, load_byte};
            2'd1:    w_word = {16'h0, load_byte, r_word[7:0]};
            2'd2:    w_word = {8'h0, load_byte, r_word[15:0]};
            default: w_word = {load_byte, r_word[23:0]};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_byte_cnt   <= 2'd0;
            r_word       <= 24'h0;
            r_wr_ptr     <= '0;
            r_word_count <= '0;
            r_ready      <= 1'b1;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (w_accept) begin
            if (w_full) begin
                r_overflow <= 1'b1;
            end else if (w_commit) begin
                r_wr_ptr   <= r_wr_ptr + PTR_ONE;
                r_byte_cnt <= 2'd0;
                r_word     <= 24'h0;
                if (r_word_count != FULL_PTR)
                    r_word_count <= r_word_count + PTR_ONE;
            end else begin
                r_word     <= w_word[23:0];
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
            // load_last closes the image even when its byte was discarded by overflow.
            if (load_last) begin
                r_state <= ST_DONE;
                r_ready <= 1'b0;
                r_done  <= 1'b1;
            end else begin
                r_state <= ST_LOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= w_word;
    end

    // Read-first: a same-cycle write to the read word returns the old contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_data <= 32'h0;
        else if (r_state != ST_DONE)
            r_data <= 32'h0;
        else if (w_out_of_range)
            r_data <= END_INSTR;
        else
            r_data <= r_mem[w_rd_idx];
    end

    assign data          = r_data;
    assign load_ready    = r_ready;
    assign load_done     = r_done;
    assign load_overflow = r_overflow;
    assign word_count    = r_word_count;
    assign core_reset_n  = r_done;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Self-checking bench: directed loads and fetches plus randomized images against a
// byte-list reference model; a second instance with a 4-word array covers overflow.
module tb_instr_mem_responder;

    localparam int          DW       = 1024;
    localparam int          AW       = 10;
    localparam logic [31:0] END_WORD = 32'h0000_1111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic [31:0]   address, data;
    logic          load_valid, load_last, load_ready, load_done, load_overflow, core_reset_n;
    logic [7:0]    load_byte;
    logic [AW:0]   word_count;

    logic [31:0]   b_address, b_data;
    logic          b_load_valid, b_load_last, b_load_ready, b_load_done, b_load_overflow, b_core_reset_n;
    logic [7:0]    b_load_byte;
    logic [2:0]    b_word_count;

    instr_mem_responder #(.DEPTH_WORDS(DW)) u_dut (
        .clk(clk), .reset_n(reset_n), .address(address), .data(data),
        .load_valid(load_valid), .load_byte(load_byte), .load_last(load_last),
        .load_ready(load_ready), .load_done(load_done), .load_overflow(load_overflow),
        .word_count(word_count), .core_reset_n(core_reset_n)
    );

    instr_mem_responder #(.DEPTH_WORDS(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .address(b_address), .data(b_data),
        .load_valid(b_load_valid), .load_byte(b_load_byte), .load_last(b_load_last),
        .load_ready(b_load_ready), .load_done(b_load_done), .load_overflow(b_load_overflow),
        .word_count(b_word_count), .core_reset_n(b_core_reset_n)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [DW];
    bit          model_known [DW];
    logic [7:0]  img [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Whole-image view: word w holds bytes 4w..4w+3, byte k in bits 8k+7:8k, missing bytes zero.
    task automatic model_store_img();
        int n = img.size();
        for (int w = 0; w < (n + 3) / 4; w++) begin
            logic [31:0] v = 32'h0;
            for (int k = 0; k < 4; k++)
                if (4 * w + k < n) v[8*k +: 8] = img[4*w + k];
            model_mem[w]   = v;
            model_known[w] = 1'b1;
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        if (addr[31:AW+2] != 0) return END_WORD;
        return model_mem[addr[AW+1:2]];
    endfunction

    task automatic send_a(input logic [7:0] b, input logic last);
        load_valid = 1'b1; load_byte = b; load_last = last;
        @(negedge clk);
        load_valid = 1'b0; load_last = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b, input logic last);
        b_load_valid = 1'b1; b_load_byte = b; b_load_last = last;
        @(negedge clk);
        b_load_valid = 1'b0; b_load_last = 1'b0;
    endtask

    // Streams img with random bubbles; while not done, reads must return NOP and the core stays in reset.
    task automatic load_img_a(input int max_gap);
        for (int i = 0; i < img.size(); i++) begin
            chk("nop_during_load", data, 32'h0);
            chk("core_rst_during_load", 32'(core_reset_n), 32'h0);
            address = $urandom_range(0, 4 * DW - 1);
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
            send_a(img[i], i == img.size() - 1);
        end
        model_store_img();
    endtask

    task automatic fetch_a(input logic [31:0] addr, input string tag);
        address = addr;
        @(negedge clk);
        chk(tag, data, model_read(addr));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        chk("rst_data", data, 32'h0);
        chk("rst_ready", 32'(load_ready), 32'h1);
        chk("rst_done", 32'(load_done), 32'h0);
        chk("rst_ovf", 32'(load_overflow), 32'h0);
        chk("rst_wc", 32'(word_count), 32'h0);
        chk("rst_core", 32'(core_reset_n), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b1; address = 32'h0;
        load_valid = 1'b0; load_byte = 8'h0; load_last = 1'b0;
        b_address = 32'h0; b_load_valid = 1'b0; b_load_byte = 8'h0; b_load_last = 1'b0;
        for (int i = 0; i < DW; i++) model_known[i] = 1'b0;
        @(negedge clk);
        do_reset();

        // Two-instruction program.
        img = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h15, 8'h00};
        load_img_a(0);
        chk("p1_done", 32'(load_done), 32'h1);
        chk("p1_core", 32'(core_reset_n), 32'h1);
        chk("p1_ready", 32'(load_ready), 32'h0);
        chk("p1_wc", 32'(word_count), 32'h2);
        address = 32'h0;
        @(negedge clk);
        chk("p1_w0", data, 32'h0000_0513);
        address = 32'h4;
        @(negedge clk);
        chk("p1_w1", data, 32'h0015_0593);
        fetch_a(32'h2, "p1_addr2");
        fetch_a(32'h6, "p1_addr6");
        fetch_a(32'h0001_0000, "p1_oor");
        fetch_a(32'h0000_1000, "p1_oor_edge");

        // Short final word, zero-padded; word 1 retained from the previous image.
        do_reset();
        img = '{8'hAA, 8'hBB, 8'hCC};
        load_img_a(0);
        chk("p2_wc", 32'(word_count), 32'h1);
        address = 32'h0;
        @(negedge clk);
        chk("p2_w0", data, 32'h00CC_BBAA);
        fetch_a(32'h4, "p2_retained");

        // Reset mid-load after 6 bytes; first word was already committed.
        do_reset();
        img = '{};
        for (int i = 0; i < 6; i++) img.push_back(8'($urandom));
        for (int i = 0; i < 6; i++) begin
            chk("ml_nop", data, 32'h0);
            chk("ml_core", 32'(core_reset_n), 32'h0);
            address = 32'h0;
            send_a(img[i], 1'b0);
        end
        chk("ml_wc_before", 32'(word_count), 32'h1);
        img = img[0:3];
        model_store_img();
        do_reset();
        chk("ml_ready", 32'(load_ready), 32'h1);
        chk("ml_wc", 32'(word_count), 32'h0);
        chk("ml_done", 32'(load_done), 32'h0);
        img = '{8'h11, 8'h22, 8'h33, 8'h44};
        load_img_a(1);
        chk("ml_reload_wc", 32'(word_count), 32'h1);
        fetch_a(32'h0, "ml_reload_w0");
        chk("ml_reload_val", data, 32'h4433_2211);
        fetch_a(32'h4, "ml_retained_w1");

        // Randomized images with bubbles.
        for (int it = 0; it < 8; it++) begin
            int n;
            do_reset();
            n = $urandom_range(1, 24);
            img = '{};
            for (int i = 0; i < n; i++) img.push_back(8'($urandom));
            load_img_a(3);
            chk("rnd_wc", 32'(word_count), 32'((n + 3) / 4));
            chk("rnd_done", 32'(load_done), 32'h1);
            chk("rnd_ready", 32'(load_ready), 32'h0);
            for (int w = 0; w < (n + 3) / 4; w++)
                fetch_a({20'h0, 10'(w), 2'($urandom)}, "rnd_word");
            if (model_known[(n + 3) / 4])
                fetch_a({20'h0, 10'((n + 3) / 4), 2'b00}, "rnd_retained");
            fetch_a($urandom | 32'h0000_1000, "rnd_oor");
        end

        // 4-word instance: 20 bytes, last four overflow.
        do_reset();
        img = '{};
        for (int i = 0; i < 20; i++) img.push_back(8'($urandom));
        for (int i = 0; i < 20; i++) begin
            if (i < 16) chk("ov_nop", b_data, 32'h0);
            if (i == 16) begin
                chk("ov_wc16", 32'(b_word_count), 32'h4);
                chk("ov_flag16", 32'(b_load_overflow), 32'h0);
                chk("ov_ready16", 32'(b_load_ready), 32'h1);
            end
            if (i == 17) chk("ov_flag17", 32'(b_load_overflow), 32'h1);
            send_b(img[i], i == 19);
        end
        chk("ov_wc", 32'(b_word_count), 32'h4);
        chk("ov_flag", 32'(b_load_overflow), 32'h1);
        chk("ov_done", 32'(b_load_done), 32'h1);
        chk("ov_ready", 32'(b_load_ready), 32'h0);
        for (int w = 0; w < 4; w++) begin
            b_address = 32'(4 * w);
            @(negedge clk);
            chk("ov_word", b_data, {img[4*w+3], img[4*w+2], img[4*w+1], img[4*w]});
        end
        b_address = 32'h10;
        @(negedge clk);
        chk("ov_oor", b_data, END_WORD);
        send_b(8'h5A, 1'b1);
        chk("ov_wc_after", 32'(b_word_count), 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
